// File: rtl/mmu_pkg.sv
// Shared types and constants for the banked memory front-end and its
// sub-word lane helper.
package mmu_pkg;

  typedef enum logic [1:0] {
    MMU_SIZE_BYTE    = 2'd0,
    MMU_SIZE_HALF    = 2'd1,
    MMU_SIZE_WORD    = 2'd2,
    MMU_SIZE_ILLEGAL = 2'd3
  } mmu_size_e;

  typedef enum logic {
    MMU_IDLE   = 1'b0,
    MMU_RMW_WR = 1'b1
  } mmu_state_e;

  localparam int MMU_BANK_SEL_W = 4;
  localparam int MMU_BANK_MAX   = 16;
  localparam int MMU_BANK_INST  = 0;
  localparam int MMU_STARVE_W   = 8;

  // Size/lane combinations that can never reach a bank.
  function automatic logic mmu_misaligned(input mmu_size_e size, input logic [1:0] lane);
    logic bad;
    case (size)
      MMU_SIZE_BYTE: bad = 1'b0;
      MMU_SIZE_HALF: bad = lane[0];
      MMU_SIZE_WORD: bad = (lane != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/subword_lane.sv
// Combinational byte/halfword lane logic: extracts and extends a load from a
// bank word, and merges right-aligned store data into an old word.
module subword_lane
  import mmu_pkg::*;
(
  input  mmu_size_e   size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = old_word[{lane, 3'b000} +: 8];
    half_sel    = lane[1] ? old_word[31:16] : old_word[15:0];
    load_data   = old_word;
    merged_word = new_data;
    case (size)
      MMU_SIZE_BYTE: begin
        load_data   = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merged_word = old_word;
        merged_word[{lane, 3'b000} +: 8] = new_data[7:0];
      end
      MMU_SIZE_HALF: begin
        load_data   = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        merged_word = old_word;
        if (lane[1]) merged_word[31:16] = new_data[15:0];
        else         merged_word[15:0]  = new_data[15:0];
      end
      default: begin
        load_data   = old_word;
        merged_word = new_data;
      end
    endcase
  end

endmodule

// File: rtl/mmu_subword_arbiter.sv
// Banked memory front-end: core load/store port with sub-word RMW, fetch port
// arbitration on the shared instruction bank. Optional: MMU_FAULT_CAPTURE_EN.
module mmu_subword_arbiter
  import mmu_pkg::*;
#(
  parameter int NUM_BANKS    = 16,
  parameter int ADDR_W       = 12,
  parameter int INST_BANK    = MMU_BANK_INST,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        core_valid,
  output logic                        core_ready,
  input  logic [31:0]                 core_addr,
  input  logic                        core_wr_ena,
  input  logic [1:0]                  core_size,
  input  logic                        core_unsigned,
  input  logic [31:0]                 core_wr_data,
  output logic [31:0]                 core_rd_data,
  output logic                        core_fault,
  input  logic                        fetch_valid,
  input  logic [31:0]                 fetch_addr,
  output logic                        fetch_ready,
  output logic [31:0]                 fetch_data,
  output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS-1:0]        bank_wr_ena,
  output logic [31:0]                 bank_wr_data,
  input  logic [NUM_BANKS*32-1:0]     bank_rd_data,
  output logic                        fault_valid,
  output logic [31:0]                 fault_addr,
  input  logic                        fault_clear
);

  localparam logic [MMU_STARVE_W-1:0]   STARVE_MAX = MMU_STARVE_W'(STARVE_LIMIT);
  localparam logic [MMU_BANK_SEL_W-1:0] INST_SEL   = MMU_BANK_SEL_W'(INST_BANK);

  mmu_state_e              state_reg;
  logic [31:0]             hold_reg;
  logic [MMU_STARVE_W-1:0] starve_cnt_reg;

  logic [MMU_BANK_SEL_W-1:0] bank_sel;
  logic                      bank_mapped;
  mmu_size_e                 size;
  logic [1:0]                lane;
  logic [ADDR_W-1:0]         core_widx;
  logic [ADDR_W-1:0]         fetch_widx;
  logic                      fault_cond;
  logic                      core_req;
  logic                      core_on_inst;
  logic                      sub_store;
  logic                      fetch_win;
  logic                      wr_go;
  logic [31:0]               core_word;
  logic [31:0]               lane_old;
  logic [31:0]               load_data;
  logic [31:0]               merged_word;

  assign bank_sel    = core_addr[31:28];
  assign bank_mapped = ({1'b0, bank_sel} < 5'(NUM_BANKS));
  assign size        = mmu_size_e'(core_size);
  assign lane        = core_addr[1:0];
  assign core_widx   = core_addr[ADDR_W+1:2];
  assign fetch_widx  = fetch_addr[ADDR_W+1:2];

  assign fault_cond   = !bank_mapped || mmu_misaligned(size, lane);
  assign core_req     = core_valid && !fault_cond;
  assign core_on_inst = core_req && (bank_sel == INST_SEL);
  assign sub_store    = core_wr_ena && (size != MMU_SIZE_WORD);

  // Fetch only takes the shared bank from an idle core once starved long enough;
  // the RMW write cycle is never interrupted.
  assign fetch_win   = fetch_valid && core_on_inst && (state_reg == MMU_IDLE) &&
                       (starve_cnt_reg == STARVE_MAX);
  assign fetch_ready = fetch_valid && !(core_on_inst && !fetch_win);
  assign fetch_data  = bank_rd_data[INST_BANK*32 +: 32];

  always_comb begin
    core_word = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_sel == MMU_BANK_SEL_W'(i)) core_word = bank_rd_data[i*32 +: 32];
    end
  end

  assign lane_old = (state_reg == MMU_RMW_WR) ? hold_reg : core_word;

  subword_lane u_lane (
    .size        (size),
    .lane        (lane),
    .is_unsigned (core_unsigned),
    .old_word    (lane_old),
    .new_data    (core_wr_data),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    core_ready   = 1'b0;
    core_fault   = 1'b0;
    core_rd_data = '0;
    wr_go        = 1'b0;
    bank_wr_data = core_wr_data;
    if (core_valid) begin
      if (state_reg == MMU_RMW_WR) begin
        core_ready   = 1'b1;
        wr_go        = core_req;
        bank_wr_data = merged_word;
      end else if (fault_cond) begin
        core_ready = 1'b1;
        core_fault = 1'b1;
      end else if (!fetch_win) begin
        core_ready = !sub_store;
        wr_go      = core_wr_ena && !sub_store;
        if (!core_wr_ena) core_rd_data = load_data;
      end
    end
    if (rst) wr_go = 1'b0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      if (gi == INST_BANK) begin : g_inst
        assign bank_addr[gi*ADDR_W +: ADDR_W] = fetch_ready ? fetch_widx : core_widx;
      end else begin : g_data
        assign bank_addr[gi*ADDR_W +: ADDR_W] = core_widx;
      end
      assign bank_wr_ena[gi] = wr_go && (bank_sel == MMU_BANK_SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= MMU_IDLE;
      hold_reg       <= '0;
      starve_cnt_reg <= '0;
    end else begin
      case (state_reg)
        MMU_IDLE: begin
          if (core_req && sub_store && !fetch_win) begin
            hold_reg  <= core_word;
            state_reg <= MMU_RMW_WR;
          end
        end
        MMU_RMW_WR: state_reg <= MMU_IDLE;
        default:    state_reg <= MMU_IDLE;
      endcase
      if (fetch_ready)
        starve_cnt_reg <= '0;
      else if (fetch_valid && core_on_inst && starve_cnt_reg != STARVE_MAX)
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

`ifdef MMU_FAULT_CAPTURE_EN
  logic        fault_valid_reg;
  logic [31:0] fault_addr_reg;

  always_ff @(posedge clk) begin
    if (rst || fault_clear) begin
      fault_valid_reg <= 1'b0;
      fault_addr_reg  <= '0;
    end else if (core_fault && !fault_valid_reg) begin
      fault_valid_reg <= 1'b1;
      fault_addr_reg  <= core_addr;
    end
  end

  assign fault_valid = fault_valid_reg;
  assign fault_addr  = fault_addr_reg;
`else
  logic unused_fault_clear;
  assign unused_fault_clear = fault_clear;
  assign fault_valid        = 1'b0;
  assign fault_addr         = '0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_addr[27:ADDR_W+2], fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

endmodule

// File: tb/tb_mmu_subword_arbiter.sv
// Bench for mmu_subword_arbiter: vector table through a scoreboard, plus
// starvation, concurrent-bank, fault-capture and reset-in-RMW sequences.
module tb_mmu_subword_arbiter;

  localparam int NB = 8;
  localparam int AW = 12;
`ifdef MMU_FAULT_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              core_valid, core_ready, core_wr_ena, core_unsigned, core_fault;
  logic [31:0]       core_addr, core_wr_data, core_rd_data;
  logic [1:0]        core_size;
  logic              fetch_valid, fetch_ready;
  logic [31:0]       fetch_addr, fetch_data;
  logic [NB*AW-1:0]  bank_addr;
  logic [NB-1:0]     bank_wr_ena;
  logic [31:0]       bank_wr_data;
  logic [NB*32-1:0]  bank_rd_data;
  logic              fault_valid, fault_clear;
  logic [31:0]       fault_addr;

  mmu_subword_arbiter #(.NUM_BANKS(NB), .ADDR_W(AW), .INST_BANK(0), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
    .core_wr_ena(core_wr_ena), .core_size(core_size), .core_unsigned(core_unsigned),
    .core_wr_data(core_wr_data), .core_rd_data(core_rd_data), .core_fault(core_fault),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .bank_addr(bank_addr), .bank_wr_ena(bank_wr_ena),
    .bank_wr_data(bank_wr_data), .bank_rd_data(bank_rd_data),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_clear(fault_clear)
  );

  always #5 clk = ~clk;

  // Bank memories: async read, write on the clock edge.
  logic [31:0] mem [NB][1<<AW];
  int          wr_count = 0;

  always_comb begin
    bank_rd_data = '0;
    for (int i = 0; i < NB; i++) bank_rd_data[i*32 +: 32] = mem[i][bank_addr[i*AW +: AW]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (bank_wr_ena[i]) mem[i][bank_addr[i*AW +: AW]] <= bank_wr_data;
    wr_count <= wr_count + $countones(bank_wr_ena);
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_fault;
    int          exp_cyc;
    int          exp_wr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  vec_t exp_q [$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_core(input vec_t v);
    vec_t e;
    bit   got;
    int   start_wr;
    start_wr      = wr_count;
    core_valid    = 1'b1;
    core_addr     = v.addr;
    core_wr_ena   = v.we;
    core_size     = v.size;
    core_unsigned = v.uns;
    core_wr_data  = v.wdata;
    exp_q.push_back(v);
    got = 1'b0;
    for (int c = 1; c <= 4 && !got; c++) begin
      @(negedge clk);
      if (core_ready) begin
        got = 1'b1;
        e   = exp_q.pop_front();
        check("rd_data", core_rd_data, e.exp_rd);
        check("fault", {31'b0, core_fault}, {31'b0, e.exp_fault});
        check("latency", 32'(c), 32'(e.exp_cyc));
        $display("txn addr=%h we=%0d size=%0d rd=%h fault=%0b cycles=%0d",
                 v.addr, v.we, v.size, core_rd_data, core_fault, c);
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL core_ready timeout addr=%h", v.addr);
      void'(exp_q.pop_front());
    end
    core_valid = 1'b0;
    check("wr_strobes", 32'(wr_count - start_wr), 32'(v.exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            addr          we    size  uns   wdata          exp_rd         flt  cyc wr
    vecs[0]  = '{32'h0000_0000, 1'b1, 2'd2, 1'b0, 32'h1111_1111, 32'h0,         1'b0, 1, 1};
    vecs[1]  = '{32'h0000_0040, 1'b1, 2'd2, 1'b0, 32'h1357_9BDF, 32'h0,         1'b0, 1, 1};
    vecs[2]  = '{32'h3000_0014, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0,         1'b0, 1, 1};
    vecs[3]  = '{32'h3000_0010, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 1};
    vecs[4]  = '{32'h3000_0013, 1'b0, 2'd0, 1'b0, 32'h0,         32'hFFFF_FFDE, 1'b0, 1, 0};
    vecs[5]  = '{32'h3000_0013, 1'b0, 2'd0, 1'b1, 32'h0,         32'h0000_00DE, 1'b0, 1, 0};
    vecs[6]  = '{32'h3000_0010, 1'b0, 2'd1, 1'b0, 32'h0,         32'hFFFF_BEEF, 1'b0, 1, 0};
    vecs[7]  = '{32'h3000_0012, 1'b1, 2'd1, 1'b0, 32'h0000_1234, 32'h0,         1'b0, 2, 1};
    vecs[8]  = '{32'h3000_0010, 1'b0, 2'd2, 1'b0, 32'h0,         32'h1234_BEEF, 1'b0, 1, 0};
    vecs[9]  = '{32'h3000_0012, 1'b0, 2'd0, 1'b0, 32'h0,         32'h0000_0034, 1'b0, 1, 0};
    vecs[10] = '{32'h3000_0011, 1'b1, 2'd0, 1'b0, 32'hFFFF_FFA5, 32'h0,         1'b0, 2, 1};
    vecs[11] = '{32'h3000_0010, 1'b0, 2'd2, 1'b0, 32'h0,         32'h1234_A5EF, 1'b0, 1, 0};
    vecs[12] = '{32'h3000_0012, 1'b0, 2'd1, 1'b1, 32'h0,         32'h0000_1234, 1'b0, 1, 0};
    vecs[13] = '{32'h3000_0011, 1'b0, 2'd0, 1'b0, 32'h0,         32'hFFFF_FFA5, 1'b0, 1, 0};
    vecs[14] = '{32'h3000_0002, 1'b0, 2'd2, 1'b0, 32'h0,         32'h0,         1'b1, 1, 0};
    vecs[15] = '{32'h3000_0011, 1'b0, 2'd1, 1'b0, 32'h0,         32'h0,         1'b1, 1, 0};
    vecs[16] = '{32'h3000_0010, 1'b0, 2'd3, 1'b0, 32'h0,         32'h0,         1'b1, 1, 0};
    vecs[17] = '{32'h3000_0012, 1'b1, 2'd2, 1'b0, 32'h0BAD_F00D, 32'h0,         1'b1, 1, 0};
    vecs[18] = '{32'h9000_0000, 1'b1, 2'd1, 1'b0, 32'h0000_7777, 32'h0,         1'b1, 1, 0};
    vecs[19] = '{32'h3000_0010, 1'b0, 2'd2, 1'b0, 32'h0,         32'h1234_A5EF, 1'b0, 1, 0};
    vecs[20] = '{32'h3000_0010, 1'b0, 2'd0, 1'b1, 32'h0,         32'h0000_00EF, 1'b0, 1, 0};

    // Reset, with a word store presented that must not reach a bank.
    rst = 1'b1; fault_clear = 1'b0;
    fetch_valid = 1'b0; fetch_addr = 32'h0;
    core_valid = 1'b1; core_addr = 32'h3000_0010; core_wr_ena = 1'b1;
    core_size = 2'd2; core_unsigned = 1'b0; core_wr_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wr_ena_in_rst", 32'(bank_wr_ena), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0; core_valid = 1'b0;
    @(negedge clk);
    check("rst_core_ready", {31'b0, core_ready}, 32'h0);
    check("rst_fetch_ready", {31'b0, fetch_ready}, 32'h0);
    check("rst_fault_valid", {31'b0, fault_valid}, 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) do_core(vecs[i]);

    // Sticky fault capture: first fault was the misaligned word load.
    check("cap_valid", {31'b0, fault_valid}, {31'b0, CAP});
    check("cap_addr", fault_addr, CAP ? 32'h3000_0002 : 32'h0);
    fault_clear = 1'b1;
    @(posedge clk); #1;
    fault_clear = 1'b0;
    @(negedge clk);
    check("clr_valid", {31'b0, fault_valid}, 32'h0);
    check("clr_addr", fault_addr, 32'h0);
    @(posedge clk); #1;
    v = '{32'h9000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0};
    do_core(v);
    check("cap2_valid", {31'b0, fault_valid}, {31'b0, CAP});
    check("cap2_addr", fault_addr, CAP ? 32'h9000_0000 : 32'h0);

    // Core hammers the instruction bank; fetch must break through every 5th cycle.
    core_valid = 1'b1; core_addr = 32'h0000_0000; core_wr_ena = 1'b0;
    core_size = 2'd2; core_unsigned = 1'b0;
    fetch_valid = 1'b1; fetch_addr = 32'h0000_0040;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check("starve_fetch_ready", {31'b0, fetch_ready}, (k % 5 == 0) ? 32'h1 : 32'h0);
      check("starve_core_ready", {31'b0, core_ready}, (k % 5 == 0) ? 32'h0 : 32'h1);
      if (fetch_ready) check("starve_fetch_data", fetch_data, 32'h1357_9BDF);
      if (core_ready)  check("starve_core_data", core_rd_data, 32'h1111_1111);
      $display("txn hammer cycle=%0d fetch_ready=%0b core_ready=%0b", k, fetch_ready, core_ready);
      @(posedge clk); #1;
    end

    // Core on bank 3 and fetch on bank 0 in the same cycle.
    core_addr = 32'h3000_0014;
    @(negedge clk);
    check("conc_core_ready", {31'b0, core_ready}, 32'h1);
    check("conc_fetch_ready", {31'b0, fetch_ready}, 32'h1);
    check("conc_core_data", core_rd_data, 32'hCAFE_F00D);
    check("conc_fetch_data", fetch_data, 32'h1357_9BDF);
    check("conc_bank0_addr", {20'b0, bank_addr[0 +: AW]}, 32'd16);
    $display("txn concurrent core=%h fetch=%h", core_rd_data, fetch_data);
    @(posedge clk); #1;
    core_valid = 1'b0; fetch_valid = 1'b0;

    // Reset lands in the RMW write cycle: the merge must be dropped.
    begin
      int start_wr;
      start_wr = wr_count;
      core_valid = 1'b1; core_addr = 32'h3000_0012; core_wr_ena = 1'b1;
      core_size = 2'd1; core_wr_data = 32'h0000_5555;
      @(negedge clk);
      check("rmw_rst_first_ready", {31'b0, core_ready}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rmw_rst_wr_ena", 32'(bank_wr_ena), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; core_valid = 1'b0;
      check("rmw_rst_no_write", 32'(wr_count - start_wr), 32'h0);
      $display("txn reset during rmw write");
    end
    v = '{32'h3000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1234_A5EF, 1'b0, 1, 0};
    do_core(v);
    v = '{32'h3000_0012, 1'b1, 2'd1, 1'b0, 32'h0000_5555, 32'h0, 1'b0, 2, 1};
    do_core(v);
    v = '{32'h3000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 32'h5555_A5EF, 1'b0, 1, 0};
    do_core(v);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmu_subword_arbiter.md
Name: mmu_subword_arbiter

Overview:
Parametrised successor to the core memory front-end. It sits between the pipeline (one load/store port and one instruction-fetch port) and NUM_BANKS single-port, async-read word banks; the bank is selected by addr[31:28].
- Adds byte/halfword/word loads and stores; sub-word stores use a two-cycle read-modify-write.
- Adds a valid/ready handshake on both ports.
- Adds fetch/core arbitration on the shared instruction bank with an anti-starvation counter.
- Adds fault reporting for misaligned and unmapped accesses.

Parameters:
NUM_BANKS, 16, number of banks decoded from addr[31:28]; range 1..16.
ADDR_W, 12, word-address width driven to each bank.
INST_BANK, 0, bank index shared by the fetch and core ports.
STARVE_LIMIT, 4, consecutive fetch-stall cycles after which fetch wins one cycle; range 1..255.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
core_valid  in  1  core request present; held stable until core_ready
core_ready  out  1  request completes this cycle
core_addr  in  32  byte address
core_wr_ena  in  1  1 = store, 0 = load
core_size  in  2  0 = byte, 1 = half, 2 = word; 3 = illegal (faults)
core_unsigned  in  1  zero-extend sub-word loads
core_wr_data  in  32  store data, right-aligned
core_rd_data  out  32  load data, extended
core_fault  out  1  misaligned/unmapped/illegal; qualified by core_ready
fetch_valid  in  1  fetch request
fetch_addr  in  32  word-aligned fetch address
fetch_ready  out  1  fetch_data valid this cycle
fetch_data  out  32  instruction word
bank_addr  out  NUM_BANKS*ADDR_W  per-bank word address
bank_wr_ena  out  NUM_BANKS  per-bank write strobe
bank_wr_data  out  32  shared write data
bank_rd_data  in  NUM_BANKS*32  per-bank async read data
fault_valid  out  1  sticky fault flag (see Optional Feature)
fault_addr  out  32  address of first fault since clear
fault_clear  in  1  clears fault_valid and fault_addr

Behaviour:
- Reset: FSM→IDLE; hold register, starve counter, fault_valid and fault_addr go to 0. core_ready and fetch_ready are combinational from IDLE and the inputs. All bank_wr_ena are 0 during rst.
- Bank index b = core_addr[31:28]; word index = core_addr[ADDR_W+1:2]; lane = core_addr[1:0].
- Fault conditions: b >= NUM_BANKS; size 3; half with addr[0] = 1; word with addr[1:0] != 0.
  - On fault: core_ready = core_fault = 1 in the same cycle, no bank write, core_rd_data = 0.
- Loads: single cycle, core_ready = 1 in the valid cycle unless lost in arbitration.
  - Lane extracted via addr[1:0], then sign- or zero-extended per core_unsigned.
- Word stores: single cycle; bank_wr_ena[b] = 1 with core_wr_data.
- Sub-word stores use FSM IDLE→RMW_WR→IDLE:
  - IDLE cycle: read the old word into the hold register; core_ready = 0.
  - RMW_WR cycle: write the merged word (new byte/half in the lane); core_ready = 1.
  - The bank stays owned by the core across both cycles.
- Arbitration when core targets INST_BANK and fetch_valid = 1 in the same cycle:
  - Core wins: fetch_ready = 0 and the starve counter increments (saturating).
  - When the counter equals STARVE_LIMIT: fetch wins that cycle, core_ready = 0, counter resets.
  - Fetch never pre-empts a cycle in RMW_WR.
  - The counter clears on any cycle in which fetch_ready = 1.
- No conflict: fetch is served from bank_rd_data[INST_BANK] with fetch_ready = fetch_valid in the same cycle, concurrently with core access to any other bank.
- Bank address: idle banks are driven the core word index. INST_BANK is driven the fetch index when fetch owns it.
- Reset during RMW_WR: the write is suppressed and the FSM returns to IDLE.
- core_valid = 0: no writes, core_ready = 0, counter unchanged.

Optional Feature:
MMU_FAULT_CAPTURE_EN
- Defined: on the first faulting completion while fault_valid = 0, fault_valid ← 1 and fault_addr ← core_addr. Later faults do not overwrite.
  - fault_clear takes priority over a simultaneous capture.
- Undefined: fault_valid and fault_addr are tied to 0; fault_clear is ignored.

Decomposition:
- Shared package mmu_pkg:
  - size enum (MMU_SIZE_BYTE/HALF/WORD)
  - FSM state enum
  - bank-index constants (MMU_BANK_INST etc.)
- One sub-module, subword_lane: pure-combinational load extraction and store merge, keyed on size, lane and unsigned. Reused by the FSM and the read path.

Test Plan:
- Word store of 0xDEADBEEF to 0x3000_0010, then signed byte load at 0x3000_0013 → 0xFFFF_FFDE in one cycle, no fault.
- Half store of 0x1234 to 0x3000_0012 over 0xDEADBEEF → core_ready low 1 cycle then high; bank holds 0x1234BEEF; exactly one write strobe.
- Word load at 0x3000_0002 → core_ready = core_fault = 1, no write; with MMU_FAULT_CAPTURE_EN, fault_addr = 0x3000_0002 until fault_clear.
- Core hammers INST_BANK every cycle with fetch_valid held, STARVE_LIMIT = 4 → fetch_ready pulses exactly every 5th cycle, core_ready low that cycle.
- Core load to bank 3 while fetching from 0x0000_0040 → both ready in the same cycle with correct data.
- rst asserted in the RMW_WR cycle → no bank_wr_ena, FSM IDLE, next half store again takes 2 cycles.
